// File: rtl/x_mem_2p_player_pkg.sv
// Shared types and constants for the 2048x2 sample-memory player.
package x_mem_player_pkg;

    localparam int unsigned ADDR_W         = 11;
    localparam int unsigned DATA_W         = 2;
    localparam int unsigned WORDS_PER_BYTE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

endpackage

// File: rtl/x_mem_2p_player_if.sv
// Host load port, playback control, DAC sample stream and memory pins of the player.
// master: the player itself; slave: host + memory side.
interface x_mem_2p_player_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DIV_W  = 16
);
    logic              i_load_valid;
    logic [7:0]        i_load_data;
    logic              o_load_ready;
    logic              i_clear;
    logic              i_start;
    logic              i_stop;
    logic [DIV_W-1:0]  i_div;
    logic [DATA_W-1:0] o_sample;
    logic              o_sample_valid;
    logic              o_done;
    logic              o_busy;
    logic [ADDR_W:0]   o_len;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        input  i_load_valid, i_load_data, i_clear, i_start, i_stop, i_div, i_mem_rdata,
        output o_load_ready, o_sample, o_sample_valid, o_done, o_busy, o_len,
               o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport slave (
        output i_load_valid, i_load_data, i_clear, i_start, i_stop, i_div, i_mem_rdata,
        input  o_load_ready, o_sample, o_sample_valid, o_done, o_busy, o_len,
               o_mem_addr, o_mem_we, o_mem_wdata
    );
endinterface

// File: rtl/x_mem_2p_player_tick.sv
// Sample-period down-counter: strobes when it reaches 0, then reloads to div.
// Held at 0 while disabled so the first strobe lands on the first enabled cycle.
module x_mem_player_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next count: reload on strobe, count down otherwise, park at 0 when disabled.
    always_comb begin
        cnt_d = '0;
        if (i_en) begin
            if (cnt_q == '0) cnt_d = i_div;
            else             cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_tick = i_en && (cnt_q == '0);
endmodule

// File: rtl/x_mem_2p_player.sv
// Sample-memory player: unpacks host bytes into 2-bit words written to the
// single-port memory, then plays them back to the DAC at a programmable period.
// Build option: X_MEM_PLAYER_LOOP_EN makes playback wrap until stopped.
module x_mem_2p_player #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    x_mem_2p_player_if.master bus
);
    import x_mem_player_pkg::*;

`ifdef X_MEM_PLAYER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int unsigned   LEN_W    = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        byte_q, byte_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              fin_q, fin_d;     // final read already issued
    logic              pend_q, pend_d;   // read issued last cycle, data arriving now
    logic              last_q, last_d;   // that read was the final word
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              sample_valid_q, sample_valid_d;
    logic              done_q, done_d;

    logic              load_ready;
    logic              play_en;
    logic              tick;
    logic              rd_fire;
    logic              last_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign play_en = (state_q == PLAY);

    x_mem_player_tick #(.DIV_W(DIV_W)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (play_en),
        .i_div  (div_q),
        .o_tick (tick)
    );

    // Next-state, memory pin drive and sample capture.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byte_d         = byte_q;
        wcnt_d         = wcnt_q;
        rd_ptr_d       = rd_ptr_q;
        div_d          = div_q;
        fin_d          = fin_q;
        pend_d         = 1'b0;
        last_d         = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        rd_fire        = 1'b0;
        load_ready     = (state_q == IDLE) && (len_q != LEN_FULL) && !bus.i_start;
        last_word      = ({1'b0, rd_ptr_q} == (len_q - LEN_W'(1)));

        case (state_q)
            IDLE: begin
                if (bus.i_start && (len_q != '0)) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                    div_d    = bus.i_div;
                    fin_d    = 1'b0;
                end else begin
                    if (bus.i_clear) len_d = '0;
                    if (bus.i_load_valid && load_ready) begin
                        state_d = LOAD;
                        byte_d  = bus.i_load_data;
                        wcnt_d  = '0;
                    end
                end
            end

            LOAD: begin
                mem_we    = 1'b1;
                mem_addr  = len_q[ADDR_W-1:0];
                mem_wdata = byte_q[DATA_W-1:0];
                byte_d    = byte_q >> DATA_W;
                len_d     = len_q + LEN_W'(1);
                wcnt_d    = wcnt_q + 2'd1;
                if (wcnt_q == 2'(WORDS_PER_BYTE - 1)) state_d = IDLE;
            end

            PLAY: begin
                rd_fire = tick && !fin_q;
                if (rd_fire) begin
                    mem_addr = rd_ptr_q;
                    if (LOOP_EN) begin
                        rd_ptr_d = last_word ? '0 : rd_ptr_q + ADDR_W'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        fin_d    = last_word;
                        last_d   = last_word;
                    end
                end
                // Stop wins over everything: the in-flight read is simply dropped.
                if (bus.i_stop) begin
                    state_d = IDLE;
                end else begin
                    pend_d = rd_fire;
                    if (pend_q) begin
                        sample_d       = bus.i_mem_rdata;
                        sample_valid_d = 1'b1;
                        if (!LOOP_EN && last_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            byte_q         <= '0;
            wcnt_q         <= '0;
            rd_ptr_q       <= '0;
            div_q          <= '0;
            fin_q          <= 1'b0;
            pend_q         <= 1'b0;
            last_q         <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_q         <= byte_d;
            wcnt_q         <= wcnt_d;
            rd_ptr_q       <= rd_ptr_d;
            div_q          <= div_d;
            fin_q          <= fin_d;
            pend_q         <= pend_d;
            last_q         <= last_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
        end
    end

    assign bus.o_load_ready   = load_ready;
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_len          = len_q;
    assign bus.o_sample       = sample_q;
    assign bus.o_sample_valid = sample_valid_q;
    assign bus.o_done         = done_q;
    assign bus.o_mem_we       = mem_we;
    assign bus.o_mem_addr     = mem_addr;
    assign bus.o_mem_wdata    = mem_wdata;
endmodule

// File: tb/tb_x_mem_2p_player.sv
// Bench for x_mem_2p_player: memory device model, cycle-level reference model
// derived from the load/playback rules, per-cycle compare, directed literals
// and a randomized traffic phase.
`timescale 1ns/1ps
module tb_x_mem_2p_player;
    localparam int AW   = 11;
    localparam int DW   = 2;
    localparam int VW   = 16;
    localparam int FULL = 2048;
`ifdef X_MEM_PLAYER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          load_valid = 1'b0;
    logic [7:0]    load_data  = '0;
    logic          clear      = 1'b0;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic [VW-1:0] div        = '0;

    x_mem_2p_player_if #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) bus ();

    x_mem_2p_player #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    assign bus.i_load_valid = load_valid;
    assign bus.i_load_data  = load_data;
    assign bus.i_clear      = clear;
    assign bus.i_start      = start;
    assign bus.i_stop       = stop;
    assign bus.i_div        = div;

    // Single-port memory device with registered read.
    logic [1:0] mem [0:FULL-1];
    logic [1:0] rdata = '0;
    always @(posedge clk) begin
        if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        else              rdata <= mem[bus.o_mem_addr];
    end
    assign bus.i_mem_rdata = rdata;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 loading, 2 playing. In play, k counts cycles since entry;
    // word j is read at k = j*(div+1) and appears on the sample port two cycles later.
    int         m_mode = 0, m_len = 0, m_wi = 0, m_k = 0, m_div = 0, m_plen = 1;
    logic [7:0] m_byte = '0;
    logic [1:0] ref_mem [0:FULL-1];
    logic [1:0] e_sample = '0;
    bit         e_valid = 1'b0, e_done = 1'b0;

    function automatic bit m_ready();
        return (m_mode == 0) && (m_len != FULL) && !start;
    endfunction

    function automatic bit m_is_read(input int k);
        int per;
        per = m_div + 1;
        if (k < 0 || (k % per) != 0) return 1'b0;
        return LOOP || ((k / per) < m_plen);
    endfunction

    always @(posedge clk) begin : model_upd
        bit rdy;
        int j;
        cyc++;
        check_en = 1'b1;
        rdy = m_ready();
        if (rst) begin
            m_mode = 0; m_len = 0; e_sample = '0; e_valid = 0; e_done = 0;
        end else begin
            e_valid = 0;
            e_done  = 0;
            case (m_mode)
                0: begin
                    if (start && m_len != 0) begin
                        m_mode = 2; m_k = 0; m_div = int'(div); m_plen = m_len;
                    end else begin
                        if (clear) m_len = 0;
                        if (load_valid && rdy) begin
                            m_mode = 1; m_byte = load_data; m_wi = 0;
                        end
                    end
                end
                1: begin
                    ref_mem[m_len] = 2'((m_byte >> (2 * m_wi)) & 8'h3);
                    m_len++;
                    m_wi++;
                    if (m_wi == 4) m_mode = 0;
                end
                default: begin
                    if (stop) begin
                        m_mode = 0;
                    end else if (m_is_read(m_k - 1)) begin
                        j = (m_k - 1) / (m_div + 1);
                        e_valid  = 1;
                        e_sample = ref_mem[j % m_plen];
                        if (!LOOP && j == m_plen - 1) begin
                            e_done = 1;
                            m_mode = 0;
                        end
                    end
                    m_k++;
                end
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin : compare
        bit         ewe;
        int         eaddr;
        logic [1:0] ewd;
        if (check_en) begin
            ewe = 0; eaddr = 0; ewd = '0;
            if (m_mode == 1) begin
                ewe = 1; eaddr = m_len; ewd = 2'((m_byte >> (2 * m_wi)) & 8'h3);
            end else if (m_mode == 2 && m_is_read(m_k)) begin
                eaddr = (m_k / (m_div + 1)) % m_plen;
            end
            chk("busy",   bus.o_busy,         m_mode != 0);
            chk("ready",  bus.o_load_ready,   m_ready());
            chk("len",    bus.o_len,          m_len);
            chk("we",     bus.o_mem_we,       ewe);
            chk("addr",   bus.o_mem_addr,     eaddr);
            if (ewe) chk("wdata", bus.o_mem_wdata, ewd);
            chk("sample", bus.o_sample,       e_sample);
            chk("svalid", bus.o_sample_valid, e_valid);
            chk("done",   bus.o_done,         e_done);
        end
    end

    // Sample monitor used by the directed literal checks.
    int sq[$];
    int sc[$];
    int done_cnt = 0;
    int done_cyc = -1;
    always @(negedge clk) begin
        if (bus.o_sample_valid) begin
            sq.push_back(int'(bus.o_sample));
            sc.push_back(cyc);
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        int budget;
        budget = 50;
        load_valid = 1'b1;
        load_data  = b;
        while (budget > 0) begin
            if (bus.o_load_ready) begin
                step();
                break;
            end
            step();
            budget--;
        end
        load_valid = 1'b0;
        chk("load_accept_timeout", budget > 0, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.o_busy && n < budget) begin
            step();
            n++;
        end
        chk(name, bus.o_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, r;
        int exp_seq [6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < FULL; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset values.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_ready", bus.o_load_ready, 1);
        chk("rst_len",   bus.o_len, 0);
        chk("rst_busy",  bus.o_busy, 0);
        chk("rst_we",    bus.o_mem_we, 0);
        chk("rst_svalid", bus.o_sample_valid, 0);

        // Byte 0xE4 unpacks to words 0,1,2,3; ready low 4 cycles.
        load_byte(8'hE4);
        n = 0;
        while (!bus.o_load_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_low_cycles", n, 4);
        chk("len_after_e4", bus.o_len, 4);
        for (int i = 0; i < 4; i++) chk("mem_e4", mem[i], i);

        // Playback with div=3.
        sq.delete(); sc.delete(); done_cnt = 0;
        div = 16'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        r = cyc;  // first read cycle
        if (!LOOP) begin
            wait_idle(100, "play_e4_timeout");
            step(3);
            chk("play_nsamples", sq.size(), 4);
            for (int i = 0; i < sq.size() && i < 4; i++) chk("play_sample", sq[i], i);
            if (sq.size() > 0) chk("first_valid_latency", sc[0] - r, 2);
            for (int i = 1; i < sc.size() && i < 4; i++) chk("valid_spacing", sc[i] - sc[i-1], 4);
            chk("done_count", done_cnt, 1);
            if (sc.size() >= 4) chk("done_with_last", done_cyc, sc[3]);
        end else begin
            while (cyc < r + 25) step();
            stop = 1'b1;  // one cycle after the read of word index 6
            step();
            stop = 1'b0;
            chk("stop_busy_low", bus.o_busy, 0);
            step(4);
            chk("loop_nsamples", sq.size(), 6);
            for (int i = 0; i < sq.size() && i < 6; i++) chk("loop_sample", sq[i], exp_seq[i]);
            if (sq.size() > 0) chk("first_valid_latency", sc[0] - r, 2);
            chk("loop_no_done", done_cnt, 0);
        end

        // Start wins over a simultaneous load.
        start = 1'b1; load_valid = 1'b1; load_data = 8'hFF; div = 16'd1;
        step();
        start = 1'b0; load_valid = 1'b0;
        chk("start_prio_busy", bus.o_busy, 1);
        chk("start_prio_len", bus.o_len, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_len", bus.o_len, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_empty_idle", bus.o_busy, 0);

        // Reset during the second write.
        load_byte(8'hA5);
        step();
        rst = 1'b1;
        step();
        chk("rstmid_we", bus.o_mem_we, 0);
        chk("rstmid_len", bus.o_len, 0);
        chk("rstmid_svalid", bus.o_sample_valid, 0);
        chk("rstmid_done", bus.o_done, 0);
        chk("rstmid_busy", bus.o_busy, 0);
        rst = 1'b0;
        step();

        // Fill to 2048 words; further bytes refused.
        for (int i = 0; i < FULL / 4; i++) load_byte(8'($urandom));
        step(5);
        chk("full_len", bus.o_len, FULL);
        load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("full_ready_low", bus.o_load_ready, 0);
            step();
        end
        load_valid = 1'b0;
        chk("full_len_hold", bus.o_len, FULL);

        // Full-buffer playback at div=0 exercises the top address.
        div = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        if (!LOOP) begin
            wait_idle(2200, "full_play_timeout");
        end else begin
            step(2100);
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk("full_loop_stop", bus.o_busy, 0);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_full_len", bus.o_len, 0);
        chk("clear_full_ready", bus.o_load_ready, 1);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            load_valid = ($urandom_range(0, 99) < 50);
            load_data  = 8'($urandom);
            start      = ($urandom_range(0, 99) < 6);
            stop       = ($urandom_range(0, 99) < 3);
            clear      = ($urandom_range(0, 99) < 2);
            div        = VW'($urandom_range(0, 3));
            step();
        end
        load_valid = 0; start = 0; stop = 1; clear = 0;
        step();
        stop = 0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
